// File: rtl/ldpc_3gpp_enc_p2_obuf_pkg.sv
// Shared types for the p2 output buffer: encoder strobe/data types and the per-bank state.
package ldpc_3gpp_enc_p2_obuf_pkg;

    typedef struct packed {
        logic sof;
        logic sop;
        logic eop;
        logic eof;
    } strb_t;

    localparam int cDAT_W = 8;
    typedef logic [cDAT_W-1:0] dat_t;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

endpackage

// File: rtl/ldpc_3gpp_enc_obuf_skid.sv
// Two-entry valid/ready skid FIFO; the head entry is the registered output.
module ldpc_3gpp_enc_obuf_skid #(
    parameter int pW = 12
) (
    input  logic          iclk,
    input  logic          ireset,
    input  logic          iclkena,
    input  logic          ival,
    input  logic [pW-1:0] idat,
    output logic [1:0]    ocnt,
    output logic          oval,
    input  logic          iordy,
    output logic [pW-1:0] odat
);

    logic [pW-1:0] tail;
    logic [1:0]    cnt;
    logic          pop;

    assign pop  = oval & iordy;
    assign oval = (cnt != 2'd0);
    assign ocnt = cnt;

    // The writer never pushes into a full FIFO without a pop in the same cycle.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            cnt  <= 2'd0;
            odat <= '0;
            tail <= '0;
        end else if (iclkena) begin
            case (cnt)
                2'd0: begin
                    if (ival) begin
                        odat <= idat;
                        cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (ival && pop) begin
                        odat <= idat;
                    end else if (ival) begin
                        tail <= idat;
                        cnt  <= 2'd2;
                    end else if (pop) begin
                        cnt <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        odat <= tail;
                        if (ival) tail <= idat;
                        else      cnt  <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/ldpc_3gpp_enc_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, common clock enable.
module ldpc_3gpp_enc_sdp_ram #(
    parameter int pADDR_W = 9,
    parameter int pDAT_W  = 8
) (
    input  logic              iclk,
    input  logic              iclkena,
    input  logic              iwe,
    input  logic [pADDR_W-1:0] iwaddr,
    input  logic [pDAT_W-1:0]  iwdat,
    input  logic              ire,
    input  logic [pADDR_W-1:0] iraddr,
    output logic [pDAT_W-1:0]  ordat
);

    logic [pDAT_W-1:0] mem [2**pADDR_W];

    always_ff @(posedge iclk) begin
        if (iclkena) begin
            if (iwe) mem[iwaddr] <= iwdat;
            if (ire) ordat <= mem[iraddr];
        end
    end

endmodule

// File: rtl/ldpc_3gpp_enc_p2_obuf.sv
// Ping-pong output buffer behind the p2 stage: one codeword per bank, drained over valid/ready.
//   state     | meaning
//   WR_IDLE   | waiting for sop on a free bank
//   WR_WRITE  | storing words of the current frame into wr_bank
//   WR_DROP   | no bank was free at sop; discarding words until eop
module ldpc_3gpp_enc_p2_obuf
    import ldpc_3gpp_enc_p2_obuf_pkg::*;
#(
    parameter int pADDR_W = 8,
    parameter int pDAT_W  = 8
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              iclkena,
    input  logic              ival,
    input  strb_t             istrb,
    input  logic [pDAT_W-1:0] idat,
    output logic              oval,
    input  logic              iordy,
    output strb_t             ostrb,
    output logic [pDAT_W-1:0] odat,
    output logic              obusy,
    output logic              oerr
);

    localparam logic [1:0] cWR_IDLE  = 2'd0;
    localparam logic [1:0] cWR_WRITE = 2'd1;
    localparam logic [1:0] cWR_DROP  = 2'd2;
    localparam logic [pADDR_W:0] cDEPTH = (pADDR_W+1)'(2**pADDR_W);
    localparam logic [pADDR_W:0] cONE   = (pADDR_W+1)'(1);

    logic [1:0]          wr_state;
    logic                wr_bank, rd_bank, fetch_bank;
    logic [pADDR_W:0]    wr_cnt;
    logic [pADDR_W-1:0]  fetch_addr;
    bank_state_t         bank_st  [2];
    logic [pADDR_W:0]    bank_len [2];
    logic                we, bank_free, wr_room;
    logic [pADDR_W-1:0]  waddr;
    logic                rd_pend, rd_sop, rd_eop;
    logic [pDAT_W-1:0]   ram_dat;
    logic [1:0]          skid_cnt;
    logic                pop, credit, fetch_ok, fetch, fetch_last;
    strb_t               skid_strb;
    logic [pDAT_W+3:0]   skid_q;
    logic                strb_unused;

    assign strb_unused = istrb.sof ^ istrb.eof;
    assign bank_free   = (bank_st[wr_bank] == BANK_EMPTY);
    assign wr_room     = (wr_cnt != cDEPTH);

    always_comb begin
        we    = 1'b0;
        waddr = wr_cnt[pADDR_W-1:0];
        if (ival) begin
            if (istrb.sop) begin
                we    = (wr_state == cWR_WRITE) | bank_free;
                waddr = '0;
            end else if (wr_state == cWR_WRITE) begin
                we = wr_room;
            end
        end
    end

    // Fetch runs ahead of the drain pointer so the next bank follows without a bubble;
    // credit counts skid entries plus the read in flight in the RAM.
    assign pop        = oval & iordy;
    assign credit     = (({1'b0, skid_cnt} + {2'b00, rd_pend}) <= ({2'b00, pop} + 3'd1));
    assign fetch_ok   = (bank_st[fetch_bank] == BANK_FULL) ||
                        ((bank_st[fetch_bank] == BANK_DRAINING) && (fetch_addr != '0));
    assign fetch      = fetch_ok & credit;
    assign fetch_last = ({1'b0, fetch_addr} == (bank_len[fetch_bank] - cONE));

    always_ff @(posedge iclk) begin
        if (ireset) begin
            wr_state   <= cWR_IDLE;
            wr_bank    <= 1'b0;
            wr_cnt     <= '0;
            rd_bank    <= 1'b0;
            fetch_bank <= 1'b0;
            fetch_addr <= '0;
            rd_pend    <= 1'b0;
            rd_sop     <= 1'b0;
            rd_eop     <= 1'b0;
            obusy      <= 1'b0;
            oerr       <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                bank_st[b]  <= BANK_EMPTY;
                bank_len[b] <= '0;
            end
        end else if (iclkena) begin
            if (ival) begin
                if (istrb.sop) begin
                    if ((wr_state == cWR_WRITE) || bank_free) begin
                        if (istrb.eop) begin
                            bank_st[wr_bank]  <= BANK_FULL;
                            bank_len[wr_bank] <= cONE;
                            wr_bank           <= ~wr_bank;
                            wr_state          <= cWR_IDLE;
                        end else begin
                            bank_st[wr_bank] <= BANK_FILLING;
                            wr_cnt           <= cONE;
                            wr_state         <= cWR_WRITE;
                        end
                    end else begin
                        oerr     <= 1'b1;
                        wr_state <= istrb.eop ? cWR_IDLE : cWR_DROP;
                    end
                end else begin
                    case (wr_state)
                        cWR_WRITE: begin
                            if (!wr_room || ((wr_cnt == (cDEPTH - cONE)) && !istrb.eop)) oerr <= 1'b1;
                            if (istrb.eop) begin
                                bank_st[wr_bank]  <= BANK_FULL;
                                bank_len[wr_bank] <= wr_room ? (wr_cnt + cONE) : cDEPTH;
                                wr_bank           <= ~wr_bank;
                                wr_state          <= cWR_IDLE;
                            end else if (wr_room) begin
                                wr_cnt <= wr_cnt + cONE;
                            end
                        end
                        cWR_DROP: if (istrb.eop) wr_state <= cWR_IDLE;
                        default:  oerr <= 1'b1;
                    endcase
                end
            end

            rd_pend <= fetch;
            if (fetch) begin
                rd_sop                 <= (fetch_addr == '0);
                rd_eop                 <= fetch_last;
                bank_st[fetch_bank]    <= BANK_DRAINING;
                if (fetch_last) begin
                    fetch_addr <= '0;
                    fetch_bank <= ~fetch_bank;
                end else begin
                    fetch_addr <= fetch_addr + pADDR_W'(1);
                end
            end
            if (pop && ostrb.eop) begin
                bank_st[rd_bank] <= BANK_EMPTY;
                rd_bank          <= ~rd_bank;
            end

            obusy <= (bank_st[0] != BANK_EMPTY) && (bank_st[1] != BANK_EMPTY);
        end
    end

    ldpc_3gpp_enc_sdp_ram #(
        .pADDR_W (pADDR_W + 1),
        .pDAT_W  (pDAT_W)
    ) u_ram (
        .iclk    (iclk),
        .iclkena (iclkena),
        .iwe     (we),
        .iwaddr  ({wr_bank, waddr}),
        .iwdat   (idat),
        .ire     (fetch),
        .iraddr  ({fetch_bank, fetch_addr}),
        .ordat   (ram_dat)
    );

    assign skid_strb.sof = rd_sop;
    assign skid_strb.sop = rd_sop;
    assign skid_strb.eop = rd_eop;
    assign skid_strb.eof = rd_eop;

    ldpc_3gpp_enc_obuf_skid #(
        .pW (pDAT_W + 4)
    ) u_skid (
        .iclk    (iclk),
        .ireset  (ireset),
        .iclkena (iclkena),
        .ival    (rd_pend),
        .idat    ({skid_strb, ram_dat}),
        .ocnt    (skid_cnt),
        .oval    (oval),
        .iordy   (iordy),
        .odat    (skid_q)
    );

    assign ostrb = skid_q[pDAT_W+3:pDAT_W];
    assign odat  = skid_q[pDAT_W-1:0];

endmodule

// File: tb/tb_ldpc_3gpp_enc_p2_obuf.sv
// Scoreboard bench for the p2 output buffer: a frame-level model predicts the drained words.
module tb_ldpc_3gpp_enc_p2_obuf;
    import ldpc_3gpp_enc_p2_obuf_pkg::*;

    localparam int DEPTH = 256;

    logic       clk = 1'b0, reset = 1'b1, clkena = 1'b1, ival = 1'b0, iordy = 1'b0;
    strb_t      istrb = '0;
    logic [7:0] idat = '0;
    logic       oval, obusy, oerr;
    strb_t      ostrb;
    logic [7:0] odat;

    always #5 clk = ~clk;

    ldpc_3gpp_enc_p2_obuf #(.pADDR_W(8), .pDAT_W(8)) dut (
        .iclk(clk), .ireset(reset), .iclkena(clkena), .ival(ival), .istrb(istrb), .idat(idat),
        .oval(oval), .iordy(iordy), .ostrb(ostrb), .odat(odat), .obusy(obusy), .oerr(oerr)
    );

    typedef struct { logic sop; logic eop; logic [7:0] dat; } word_t;
    word_t      exp_q[$];
    logic [7:0] cur[$];
    int errors = 0, checks = 0, cyc = 0, pops = 0;
    int m_pend = 0;
    bit m_in_frame = 0, m_err = 0;
    int iordy_mode = 1;
    bit lat_arm = 0, contig_arm = 0, busy_watch = 0;
    int lat_eop_cyc = 0, last_pop_cyc = -1;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Frame-level reference: a frame is kept if a bank is free at its sop, truncated to DEPTH words.
    task automatic mdl_word(bit sop, bit eop, logic [7:0] d);
        if (sop) begin
            if (m_in_frame) cur.delete();
            else if (m_pend < 2) begin m_in_frame = 1; m_pend++; cur.delete(); end
            else begin m_err = 1; return; end
        end else if (!m_in_frame) begin
            m_err = 1;
            return;
        end
        if (cur.size() < DEPTH) begin
            cur.push_back(d);
            if (cur.size() == DEPTH && !eop) m_err = 1;
        end else m_err = 1;
        if (eop) begin
            foreach (cur[i]) exp_q.push_back('{sop: (i == 0), eop: (i == cur.size() - 1), dat: cur[i]});
            m_in_frame = 0;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk); #1;
        case (iordy_mode)
            0:       iordy = 1'b0;
            1:       iordy = 1'b1;
            default: iordy = 1'($urandom_range(0, 1));
        endcase
    end

    logic       prev_hold = 1'b0;
    strb_t      prev_strb;
    logic [7:0] prev_dat;
    always @(negedge clk) begin : mon
        word_t w;
        if (reset) prev_hold = 1'b0;
        else begin
            if (prev_hold) begin
                check("hold_oval", oval, 1);
                check("hold_odat", odat, prev_dat);
                check("hold_strb", {ostrb.sop, ostrb.eop}, {prev_strb.sop, prev_strb.eop});
            end
            if (busy_watch) check("obusy_single", obusy, 0);
            if (oval && lat_arm && ostrb.sop) begin
                check("latency", cyc - lat_eop_cyc, 2);
                lat_arm = 0;
            end
            if (oval && iordy) begin
                pops++;
                if (contig_arm) begin
                    if (last_pop_cyc >= 0) check("no_bubble", cyc - last_pop_cyc, 1);
                    last_pop_cyc = cyc;
                end
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_word: got %0h expected no word", odat);
                end else begin
                    w = exp_q.pop_front();
                    check("odat", odat, w.dat);
                    check("sop", ostrb.sop, w.sop);
                    check("eop", ostrb.eop, w.eop);
                    if (w.eop) m_pend--;
                end
            end
            prev_hold = oval && !iordy;
            prev_dat  = odat;
            prev_strb = ostrb;
        end
    end

    task automatic drive(bit sop, bit eop, logic [7:0] d, bit lat);
        ival = 1'b1;
        istrb.sof = sop; istrb.sop = sop; istrb.eop = eop; istrb.eof = eop;
        idat = d;
        mdl_word(sop, eop, d);
        if (eop && lat) begin lat_eop_cyc = cyc + 1; lat_arm = 1; end
        @(posedge clk); #1;
    endtask

    task automatic idle(int n);
        ival = 1'b0; istrb = '0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(int n, logic [7:0] base, bit rnd, bit lat);
        for (int i = 0; i < n; i++)
            drive(i == 0, i == n - 1, rnd ? 8'($urandom) : 8'(base + i), lat);
    endtask

    task automatic wait_drain(string name);
        int n = 0;
        while ((exp_q.size() != 0 || m_pend != 0) && n < 3000) begin @(posedge clk); #1; n++; end
        check(name, exp_q.size() + m_pend, 0);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, n;
        repeat (3) @(posedge clk); #1;
        check("rst_oval", oval, 0);
        check("rst_obusy", obusy, 0);
        check("rst_oerr", oerr, 0);
        check("rst_ostrb", ostrb, 0);
        check("rst_odat", odat, 0);
        reset = 1'b0;
        idle(2);

        // single 4-word frame, full-rate drain
        busy_watch = 1; contig_arm = 1; last_pop_cyc = -1;
        send_frame(4, 8'h11, 0, 1);
        idle(0);
        wait_drain("drain_single");
        check("lat_seen", lat_arm, 0);
        busy_watch = 0; contig_arm = 0;

        // back-to-back frames, no bubble across the bank switch
        contig_arm = 1; last_pop_cyc = -1;
        send_frame(3, 8'h21, 0, 0);
        send_frame(3, 8'h41, 0, 0);
        idle(0);
        wait_drain("drain_b2b");
        contig_arm = 0;

        // full-depth frame under random backpressure
        iordy_mode = 2;
        send_frame(256, 8'h00, 1, 0);
        idle(0);
        wait_drain("drain_256");
        check("oerr_256", oerr, 0);

        // random frames and gaps
        for (int f = 0; f < 8; f++) begin
            n = 0;
            while (m_pend >= 2 && n < 600) begin @(posedge clk); #1; n++; end
            check("rand_slot", m_pend < 2, 1);
            send_frame($urandom_range(1, 24), 8'h00, 1, 0);
            idle($urandom_range(0, 3));
        end
        wait_drain("drain_rand");
        check("oerr_rand", oerr, m_err);

        // three frames with no drain: third is dropped
        iordy_mode = 0;
        idle(2);
        send_frame(3, 8'h31, 0, 0);
        send_frame(3, 8'h51, 0, 0);
        idle(2);
        check("obusy_full", obusy, 1);
        check("oerr_before_drop", oerr, 0);
        send_frame(2, 8'h71, 0, 0);
        idle(2);
        check("oerr_drop", oerr, m_err);
        check("oerr_drop_set", oerr, 1);
        iordy_mode = 1;
        wait_drain("drain_two");
        check("obusy_after", obusy, 0);

        // reset in the middle of a drain
        p0 = pops;
        send_frame(6, 8'h81, 0, 0);
        idle(0);
        n = 0;
        while (pops < p0 + 3 && n < 100) begin @(posedge clk); #1; n++; end
        check("oval_before_reset", oval, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete(); cur.delete(); m_pend = 0; m_in_frame = 0; m_err = 0;
        @(negedge clk);
        check("post_rst_oval", oval, 0);
        check("post_rst_obusy", obusy, 0);
        check("post_rst_oerr", oerr, 0);
        @(posedge clk); #1;
        send_frame(2, 8'hC1, 0, 1);
        idle(0);
        wait_drain("drain_after_reset");
        check("lat_after_reset", lat_arm, 0);

        // word without sop, then sop restart mid-frame
        check("oerr_pre_restart", oerr, 0);
        drive(0, 0, 8'h99, 0);
        drive(1, 0, 8'hA0, 0);
        drive(0, 0, 8'hA1, 0);
        drive(1, 0, 8'hB0, 0);
        drive(0, 1, 8'hB1, 0);
        idle(0);
        wait_drain("drain_restart");
        check("oerr_restart", oerr, m_err);
        check("oerr_restart_set", oerr, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
